// File: rtl/wdt_sup_pkg.sv
// Shared types and constants for the watchdog supervisor: FSM states,
// config register addresses and the kick key.
package wdt_sup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_WARN   = 2'd2,
    ST_RSTREQ = 2'd3
  } wdt_state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_TOCNT   = 2'd1;
  localparam logic [1:0] ADDR_KICK    = 2'd2;
  localparam logic [1:0] ADDR_STATCLR = 2'd3;

  localparam logic [31:0] KICK_MAGIC = 32'h5A5A_A5A5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wdt_kick_stretch.sv
// Restartable pulse stretcher: live goes high the cycle after start and stays
// high for HOLD cycles; a new start reloads the count, abort drops it at once.
module wdt_kick_stretch #(
  parameter int HOLD = 16
) (
  input  logic clk2,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic live
);

  localparam int HW = $clog2(HOLD + 1);

  logic [HW-1:0] cnt;

  always_ff @(posedge clk2) begin
    if (rst || abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= HW'(HOLD);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign live = (cnt != '0);

endmodule

// File: rtl/wdt_supervisor.sv
// Watchdog supervisor: config/kick handling and two-stage timeout escalation, latency 1;
// cfg_ready drops only in RSTREQ. Define WDT_KICK_LOCK_EN to require KICK_MAGIC on kicks.
module wdt_supervisor
  import wdt_sup_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int KICK_HOLD = 16,
  parameter int GRACE_CYC = 1024,
  parameter int RST_PULSE = 32
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             cfg_err,
  input  logic             wto,
  output logic             wden,
  output logic             wdlive,
  output logic [CNT_W-1:0] wtocnt,
  output logic             irq,
  output logic             sys_rst_req,
  output logic [7:0]       warn_cnt
);

  localparam int GW = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1;
  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYC - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

  wdt_state_t       state, state_n;
  logic             wto_q;
  logic [GW-1:0]    grace_cnt, grace_n;
  logic [PW-1:0]    pulse_cnt, pulse_n;
  logic [CNT_W-1:0] wtocnt_n;
  logic [7:0]       warn_n;
  logic             irq_n, err_n;
  logic             kick_go, kick_abort;

  logic acc, wr_ctrl, wr_tocnt, wr_kick, wr_statclr, wto_edge, kick_ok, dis_req;

  assign acc        = cfg_valid & cfg_ready;
  assign wr_ctrl    = acc && (cfg_addr == ADDR_CTRL);
  assign wr_tocnt   = acc && (cfg_addr == ADDR_TOCNT);
  assign wr_kick    = acc && (cfg_addr == ADDR_KICK);
  assign wr_statclr = acc && (cfg_addr == ADDR_STATCLR);
  assign dis_req    = wr_ctrl && !cfg_wdata[0];
  assign wto_edge   = wto & ~wto_q;

`ifdef WDT_KICK_LOCK_EN
  assign kick_ok = (cfg_wdata == KICK_MAGIC);
`else
  assign kick_ok = 1'b1;
`endif

  always_ff @(posedge clk2) begin
    if (rst) begin
      state     <= ST_IDLE;
      wto_q     <= 1'b0;
      grace_cnt <= '0;
      pulse_cnt <= '0;
      wtocnt    <= '0;
      warn_cnt  <= '0;
      irq       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      wto_q     <= wto;
      grace_cnt <= grace_n;
      pulse_cnt <= pulse_n;
      wtocnt    <= wtocnt_n;
      warn_cnt  <= warn_n;
      irq       <= irq_n;
      cfg_err   <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    grace_n    = grace_cnt;
    pulse_n    = pulse_cnt;
    wtocnt_n   = wtocnt;
    warn_n     = wr_statclr ? 8'd0 : warn_cnt;
    irq_n      = irq;
    err_n      = 1'b0;
    kick_go    = 1'b0;
    kick_abort = 1'b0;

    case (state)
      ST_IDLE: begin
        if (wr_ctrl && cfg_wdata[0]) begin
          if (wtocnt != '0) state_n = ST_ARMED;
          else              err_n   = 1'b1;
        end
        if (wr_tocnt) wtocnt_n = cfg_wdata[CNT_W-1:0];
        if (wr_kick)  err_n    = 1'b1;
      end

      ST_ARMED: begin
        if (dis_req) begin
          state_n    = ST_IDLE;
          irq_n      = 1'b0;
          grace_n    = '0;
          kick_abort = 1'b1;
        end else begin
          // A kick landing with the timeout edge still stretches, but WARN is entered.
          if (wr_kick) begin
            if (kick_ok) kick_go = 1'b1;
            else         err_n   = 1'b1;
          end
          if (wto_edge) begin
            state_n = ST_WARN;
            irq_n   = 1'b1;
            grace_n = '0;
            warn_n  = sat_inc8(warn_n);
          end
        end
        if (wr_tocnt) err_n = 1'b1;
      end

      ST_WARN: begin
        if (dis_req) begin
          state_n    = ST_IDLE;
          irq_n      = 1'b0;
          grace_n    = '0;
          kick_abort = 1'b1;
        end else if (wr_kick && kick_ok) begin
          kick_go = 1'b1;
          state_n = ST_ARMED;
          irq_n   = 1'b0;
        end else begin
          if (wr_kick) err_n = 1'b1;
          if (wto_edge || (grace_cnt == GRACE_LAST)) begin
            state_n    = ST_RSTREQ;
            pulse_n    = '0;
            kick_abort = 1'b1;
          end else begin
            grace_n = grace_cnt + 1'b1;
          end
        end
        if (wr_tocnt) err_n = 1'b1;
      end

      ST_RSTREQ: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_n = ST_IDLE;
          irq_n   = 1'b0;
        end else begin
          pulse_n = pulse_cnt + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready   = (state != ST_RSTREQ);
    wden        = (state == ST_ARMED) || (state == ST_WARN);
    sys_rst_req = (state == ST_RSTREQ);
  end

  wdt_kick_stretch #(
    .HOLD (KICK_HOLD)
  ) u_kick_stretch (
    .clk2  (clk2),
    .rst   (rst),
    .start (kick_go),
    .abort (kick_abort),
    .live  (wdlive)
  );

endmodule

// File: doc/wdt_supervisor.md
Name: wdt_supervisor

Overview:
- Control/sequencing block for the watchdog timer, in the clk2 domain.
- Accepts a simple valid/ready config/kick interface from the bus-side glue and drives the watchdog's enable, kick and timeout-count inputs.
- Monitors the watchdog timeout and escalates in two stages: first a warning interrupt, then, if software fails to respond, a system-reset request.

Parameters:
- CNT_W, 32, width of timeout count.
- KICK_HOLD, 16, clk2 cycles wdlive is held high per kick. Must cover the watchdog's slow-domain sampling interval.
- GRACE_CYC, 1024, clk2 cycles allowed in WARN before escalation.
- RST_PULSE, 32, clk2 cycles sys_rst_req is held.

Ports:
- clk2  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted when valid&&ready.
- cfg_addr  in  2  0=CTRL, 1=TOCNT, 2=KICK, 3=STATCLR.
- cfg_wdata  in  32  write data.
- cfg_err  out  1  one-cycle pulse: last accepted request was rejected.
- wto  in  1  watchdog timeout from the watchdog timer.
- wden  out  1  watchdog enable.
- wdlive  out  1  kick level, stretched.
- wtocnt  out  CNT_W  timeout count to the watchdog.
- irq  out  1  warning interrupt, level.
- sys_rst_req  out  1  system reset request.
- warn_cnt  out  8  saturating count of WARN entries.

Behaviour:
- Reset: rst is synchronous, active-high, on clk2. All outputs 0 except cfg_ready=1. State IDLE. Stretch counter and grace counter cleared.
- rst mid-operation aborts any kick stretch or reset pulse immediately.
- Handshake:
  - cfg_ready=1 in all states except RSTREQ.
  - A request is accepted on a clk2 edge with cfg_valid&&cfg_ready.
  - All effects, including cfg_err, are visible the next cycle. Latency 1.
- States: IDLE, ARMED, WARN, RSTREQ.
- wto rising edge: wto is registered once; edge = wto & ~wto_q.
- CTRL write, bit0=1:
  - In IDLE with wtocnt!=0: go to ARMED, wden=1.
  - In IDLE with wtocnt==0: cfg_err, stay IDLE.
  - In ARMED/WARN: no effect.
- CTRL write, bit0=0:
  - In ARMED/WARN: go to IDLE, wden=0, irq=0, grace counter cleared, kick stretch aborted.
  - In IDLE: no effect.
- TOCNT write:
  - In IDLE: wtocnt<=cfg_wdata[CNT_W-1:0].
  - In any other state: ignored, cfg_err.
- KICK write:
  - In ARMED/WARN: wdlive=1 for exactly KICK_HOLD cycles.
  - A kick during an active stretch restarts the hold counter; there is no double toggle.
  - In WARN, a kick also clears irq and returns to ARMED.
  - In IDLE: ignored, cfg_err.
- STATCLR write: warn_cnt<=0 in any accepting state.
- ARMED: a wto edge moves to WARN, sets irq=1, warn_cnt+1 saturating at 255, and clears the grace counter.
- WARN:
  - Grace counter increments each cycle.
  - At GRACE_CYC-1 with no kick, go to RSTREQ.
  - A second wto edge in WARN goes to RSTREQ immediately.
- RSTREQ:
  - sys_rst_req=1, wden=0, wdlive=0, for RST_PULSE cycles.
  - Then go to IDLE with irq=0. wtocnt and warn_cnt are retained.
- wto is ignored in IDLE and RSTREQ.
- Same-cycle priority, high to low: rst > CTRL disable > KICK > second wto edge / grace expiry.
- Same-cycle wto edge and accepted KICK in ARMED: go to WARN, irq=1, and the kick stretch still starts.

Optional Feature:
- Macro: WDT_KICK_LOCK_EN.
- Defined: a KICK is honoured only if cfg_wdata==32'h5A5A_A5A5. Any other value gives cfg_err and is not treated as a kick; in WARN this means no irq clear.
- Undefined: cfg_wdata is ignored on KICK.

Decomposition:
- Package wdt_sup_pkg holds:
  - state enum (IDLE, ARMED, WARN, RSTREQ);
  - cfg address constants;
  - KICK_MAGIC constant.
- One sub-module, wdt_kick_stretch: restartable pulse stretcher that produces the KICK_HOLD-cycle wdlive level.

Test Plan:
- TOCNT=100, CTRL=1 -> wden=1 and wtocnt=100 the cycle after acceptance. CTRL=1 with wtocnt=0 -> cfg_err pulse, wden stays 0.
- In ARMED, KICK -> wdlive high exactly 16 cycles. Second KICK at cycle 10 -> wdlive high until cycle 26.
- Pulse wto in ARMED -> irq=1, warn_cnt=1. KICK at cycle 500 -> irq=0, state ARMED.
- Pulse wto, no kick -> sys_rst_req high cycles 1024..1055 after entry to WARN, wden=0, then IDLE. Second wto 10 cycles into WARN -> immediate RSTREQ.
- TOCNT write while ARMED -> cfg_err, wtocnt unchanged. cfg_valid in RSTREQ -> cfg_ready=0, no accept.
- With WDT_KICK_LOCK_EN: KICK data 0x0 in WARN -> cfg_err, irq stays 1. Data 0x5A5AA5A5 -> irq=0.
